// File: rtl/binary_to_bcd_seq_if.sv
// binary_to_bcd_seq_if: start/done handshake bundle; BIN2BCD_OVERFLOW_EN adds overflow
interface binary_to_bcd_seq_if #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [WIDTH-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
`ifdef BIN2BCD_OVERFLOW_EN
    logic                  overflow;
    modport master (output start, bin, input busy, done, bcd, overflow);
    modport slave  (input start, bin, output busy, done, bcd, overflow);
`else
    modport master (output start, bin, input busy, done, bcd);
    modport slave  (input start, bin, output busy, done, bcd);
`endif
endinterface

// File: rtl/binary_to_bcd_seq.sv
// binary_to_bcd_seq: one-bit-per-clock double-dabble converter; BIN2BCD_OVERFLOW_EN adds overflow flag
module binary_to_bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input logic clk,
    input logic rst,
    binary_to_bcd_seq_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int RW = BW + WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t        state, state_n;
    logic [RW-1:0] sr, adj, shifted;
    logic [CW-1:0] cnt;
    logic [BW-1:0] bcd_q;
    logic          done_q;
    logic          last;

    // add 3 to every digit nibble >= 5, then shift the adjusted value
    always_comb begin
        adj = sr;
        for (int i = 0; i < DIGITS; i++)
            if (sr[WIDTH+4*i +: 4] >= 4'd5) adj[WIDTH+4*i +: 4] = sr[WIDTH+4*i +: 4] + 4'd3;
        shifted = {adj[RW-2:0], 1'b0};
        last    = cnt == CW'(1);
    end

    // next state: launch on start in IDLE, return after the final shift
    always_comb begin
        state_n = state;
        state_n = (state == IDLE) ? (bus.start ? SHIFT : IDLE) : (last ? IDLE : SHIFT);
    end

    // state register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else     state <= state_n;

    // working register, bit counter and registered result/done pulse
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sr     <= '0;
            cnt    <= '0;
            bcd_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                if (bus.start) begin
                    sr  <= {{BW{1'b0}}, bus.bin};
                    cnt <= CW'(WIDTH);
                end
            end else begin
                sr  <= shifted;
                cnt <= cnt - CW'(1);
                if (last) begin
                    bcd_q  <= shifted[RW-1 -: BW];
                    done_q <= 1'b1;
                end
            end
        end

    assign bus.busy = state == SHIFT;
    assign bus.done = done_q;
    assign bus.bcd  = bcd_q;

`ifdef BIN2BCD_OVERFLOW_EN
    localparam logic [31:0] LIMIT = 32'(10 ** DIGITS);

    logic ovf_q, ovf;

    // capture range check at launch, publish it alongside done
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ovf_q <= 1'b0;
            ovf   <= 1'b0;
        end else if (state == IDLE && bus.start) begin
            ovf_q <= 32'(bus.bin) >= LIMIT;
            ovf   <= 1'b0;
        end else if (state == SHIFT && last) begin
            ovf   <= ovf_q;
        end

    assign bus.overflow = ovf;
`endif
endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// tb_binary_to_bcd_seq: directed checks of binary_to_bcd_seq (overflow cases with BIN2BCD_OVERFLOW_EN)
module tb_binary_to_bcd_seq;
`ifdef BIN2BCD_OVERFLOW_EN
    localparam int D = 2;
`else
    localparam int D = 3;
`endif
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   k, bc, dn;

    binary_to_bcd_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();

    binary_to_bcd_seq #(.WIDTH(W), .DIGITS(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] to_bcd(input int v);
        logic [31:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [W-1:0] v);
        @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = v;
    endtask

    // k = index of the negedge showing done (0 = right after accepting edge), bc = busy cycles seen
    task automatic wait_done(output int kk, output int bb);
        kk = -1;
        bb = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.done) begin
                kk = i;
                break;
            end
            if (bus.busy) bb++;
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.bin   = '0;
        #2;
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_bcd", 32'(bus.bcd), 0);
        @(negedge clk);
        rst = 1'b0;

        launch(8'd0);
        wait_done(k, bc);
        check("zero_latency", k, W);
        check("zero_busy_cycles", bc, W);
        check("zero_bcd", 32'(bus.bcd), to_bcd(0));
        check("zero_busy_in_done", 32'(bus.busy), 0);
        @(negedge clk);
        check("done_single_pulse", 32'(bus.done), 0);

        launch(8'd255);
        wait_done(k, bc);
        check("full_scale_latency", k, W);
        check("full_scale_bcd", 32'(bus.bcd), to_bcd(255));
`ifndef BIN2BCD_OVERFLOW_EN
        check("full_scale_literal", 32'(bus.bcd), 32'h255);
`endif
        repeat (3) @(negedge clk);
        check("idle_hold_bcd", 32'(bus.bcd), to_bcd(255));

        for (int v = 0; v < 256; v++) begin
            launch(W'(v));
            wait_done(k, bc);
            check($sformatf("sweep_%0d", v), 32'(bus.bcd), to_bcd(v));
        end

        launch(8'd42);
        dn = 0;
        repeat (3) @(negedge clk);
        bus.start = 1'b1;
        bus.bin   = 8'd99;
        @(negedge clk);
        bus.start = 1'b0;
        k = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) begin
                k = i;
                break;
            end
            @(negedge clk);
        end
        check("busy_start_done_seen", 32'(k >= 0), 1);
        check("busy_start_bcd", 32'(bus.bcd), to_bcd(42));
        bus.start = 1'b1;
        bus.bin   = 8'd99;
        @(negedge clk);
        check("b2b_busy", 32'(bus.busy), 1);
        check("b2b_done_low", 32'(bus.done), 0);
        bus.start = 1'b0;
        k = -1;
        for (int i = 1; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) begin
                k = i;
                break;
            end
        end
        check("b2b_latency", k, W);
        check("b2b_bcd", 32'(bus.bcd), to_bcd(99));

        launch(8'd200);
        repeat (4) @(negedge clk);
        bus.start = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_busy", 32'(bus.busy), 0);
        check("rst_mid_bcd", 32'(bus.bcd), 0);
        check("rst_mid_done", 32'(bus.done), 0);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.done) dn++;
        end
        check("rst_no_done", dn, 0);
        launch(8'd7);
        wait_done(k, bc);
        check("after_rst_latency", k, W);
        check("after_rst_bcd", 32'(bus.bcd), to_bcd(7));

`ifdef BIN2BCD_OVERFLOW_EN
        launch(8'd150);
        wait_done(k, bc);
        check("ovf_bcd", 32'(bus.bcd), 32'h50);
        check("ovf_flag", 32'(bus.overflow), 1);
        @(negedge clk);
        check("ovf_held", 32'(bus.overflow), 1);
        launch(8'd99);
        @(negedge clk);
        bus.start = 1'b0;
        check("ovf_cleared_on_start", 32'(bus.overflow), 0);
        wait_done(k, bc);
        check("noovf_bcd", 32'(bus.bcd), 32'h99);
        check("noovf_flag", 32'(bus.overflow), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
